// File: rtl/bfm_pkg.sv
// Shared definitions for the bfm_core arithmetic stage: operation codes and the
// width-generic ALU function used by the datapath.
package bfm_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;

    localparam int unsigned MAX_W = 32;

    // Operands are masked to w bits; one extra bit carries the add carry / sub borrow.
    function automatic logic [MAX_W-1:0] alu_f(
        input logic [2:0]       op,
        input logic             sat,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      w
    );
        logic [MAX_W:0]   one_s;
        logic [MAX_W:0]   mask_s;
        logic [MAX_W:0]   wide_s;
        logic [MAX_W-1:0] am_s;
        logic [MAX_W-1:0] bm_s;
        logic [MAX_W-1:0] res_s;
        one_s  = {{MAX_W{1'b0}}, 1'b1};
        mask_s = (one_s << w) - one_s;
        am_s   = a & mask_s[MAX_W-1:0];
        bm_s   = b & mask_s[MAX_W-1:0];
        wide_s = {(MAX_W+1){1'b0}};
        res_s  = {MAX_W{1'b0}};
        case (op)
            OP_SUB: begin
                wide_s = {1'b0, am_s} - {1'b0, bm_s};
                if (sat && (am_s < bm_s)) begin
                    res_s = {MAX_W{1'b0}};
                end else begin
                    res_s = wide_s[MAX_W-1:0] & mask_s[MAX_W-1:0];
                end
            end
            OP_XOR:  res_s = am_s ^ bm_s;
            OP_AND:  res_s = am_s & bm_s;
            OP_OR:   res_s = am_s | bm_s;
            default: begin
                wide_s = {1'b0, am_s} + {1'b0, bm_s};
                if (sat && ((wide_s & ~mask_s) != {(MAX_W+1){1'b0}})) begin
                    res_s = mask_s[MAX_W-1:0];
                end else begin
                    res_s = wide_s[MAX_W-1:0] & mask_s[MAX_W-1:0];
                end
            end
        endcase
        return res_s;
    endfunction

endpackage

// File: rtl/bfm_if.sv
// Operand/result bundle between the stimulus wrapper (master) and bfm_core (slave).
interface bfm_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A_s;
    logic [WIDTH-1:0] B_s;
    logic [WIDTH-1:0] res_o;

    modport master (output A_s, output B_s, input res_o);
    modport slave  (input A_s, input B_s, output res_o);
endinterface

// File: rtl/bfm_pipe.sv
// Fixed-depth delay line with asynchronous active-low clear of every stage.
module bfm_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift register: each stage takes the previous one every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];
endmodule

// File: rtl/bfm_core.sv
// Registered two-operand arithmetic stage: ALU result registered in stage 0, then
// LATENCY-1 plain delay stages; res_o is always a flop output.
module bfm_core
    import bfm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int OP       = 0,
    parameter int SATURATE = 0,
    parameter int LATENCY  = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    bfm_if.slave bus
);
    // Unknown op codes fall back to add.
    localparam logic [2:0] OP_SEL  = (OP >= 0 && OP <= 4) ? 3'(OP) : OP_ADD;
    localparam logic       SAT_SEL = (SATURATE != 0) ? 1'b1 : 1'b0;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("bfm_core: LATENCY must be in 1..4");
    end
    if (WIDTH < 1 || WIDTH > MAX_W) begin : g_bad_width
        $error("bfm_core: WIDTH out of supported range");
    end

    logic [WIDTH-1:0] alu_s;
    logic [WIDTH-1:0] stage0_r;

    assign alu_s = WIDTH'(alu_f(OP_SEL, SAT_SEL, MAX_W'(bus.A_s), MAX_W'(bus.B_s), WIDTH));

    // Stage 0: sample the ALU result; reset holds it at zero regardless of inputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stage0_r <= {WIDTH{1'b0}};
        end else begin
            stage0_r <= alu_s;
        end
    end

    if (LATENCY > 1) begin : g_pipe
        bfm_pipe #(
            .WIDTH (WIDTH),
            .DEPTH (LATENCY - 1)
        ) u_pipe (
            .clk   (clk_i),
            .rst_n (reset_i),
            .din   (stage0_r),
            .dout  (bus.res_o)
        );
    end else begin : g_direct
        assign bus.res_o = stage0_r;
    end
endmodule

// File: tb/tb_bfm_core.sv
// Scoreboard bench for bfm_core: eight configurations share one operand stream and
// are checked against a plain-arithmetic model of the operations.
module tb_bfm_core;
    localparam int NDUT = 8;
    localparam int OPS  [NDUT] = '{0, 0, 1, 2, 3, 4, 0, 1};
    localparam int SATS [NDUT] = '{0, 1, 1, 0, 0, 0, 0, 0};
    localparam int LATS [NDUT] = '{1, 1, 2, 3, 4, 1, 3, 1};

    // Directed vectors: operands, instance to look at, required result.
    localparam int DN = 11;
    localparam logic [7:0] DA   [DN] = '{8'h12, 8'hFF, 8'h80, 8'hF0, 8'h10, 8'h20, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'hFF};
    localparam logic [7:0] DB   [DN] = '{8'h34, 8'h01, 8'h80, 8'h20, 8'h20, 8'h10, 8'h3C, 8'h3C, 8'h3C, 8'h01, 8'h01};
    localparam int         DD   [DN] = '{0, 0, 0, 1, 2, 2, 3, 4, 5, 7, 1};
    localparam logic [7:0] DEXP [DN] = '{8'h46, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h10, 8'hCC, 8'h30, 8'hFC, 8'hFF, 8'hFF};

    logic       clk;
    logic       reset_i;
    logic [7:0] a_drv;
    logic [7:0] b_drv;
    logic [7:0] res_w [NDUT];
    logic [8:0] sb_q  [NDUT][$];
    int         n_checks;
    int         n_fail;

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bfm_if #(.WIDTH(8)) bus ();
        assign bus.A_s  = a_drv;
        assign bus.B_s  = b_drv;
        assign res_w[g] = bus.res_o;
        bfm_core #(
            .WIDTH    (8),
            .OP       (OPS[g]),
            .SATURATE (SATS[g]),
            .LATENCY  (LATS[g])
        ) u_dut (
            .clk_i   (clk),
            .reset_i (reset_i),
            .bus     (bus)
        );
    end

    function automatic logic [7:0] ref_model(input int op, input int sat, input int a, input int b);
        int r;
        case (op)
            1: begin
                r = a - b;
                if (r < 0) r = (sat != 0) ? 0 : r + 256;
            end
            2:       r = a ^ b;
            3:       r = a & b;
            4:       r = a | b;
            default: begin
                r = a + b;
                if (r > 255) r = (sat != 0) ? 255 : r - 256;
            end
        endcase
        return 8'(r);
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got 0x%02h, expected 0x%02h", name, idx, $time, act, exp);
        end
    endtask

    // Anything still in flight is lost when the pipeline is cleared.
    task automatic clear_all();
        for (int g = 0; g < NDUT; g++) begin
            for (int i = 0; i < sb_q[g].size(); i++) begin
                sb_q[g][i] = {1'b0, sb_q[g][i][7:0]};
            end
        end
    endtask

    // Sets up the operands for the next rising edge; optional async reset pulse between edges.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic rst_lvl, input bit pulse);
        @(negedge clk);
        a_drv   = a;
        b_drv   = b;
        reset_i = rst_lvl;
        if (pulse) begin
            #1 reset_i = 1'b0;
            #1;
            for (int g = 0; g < NDUT; g++) check("async_clear", g, res_w[g], 8'h00);
            #1 reset_i = rst_lvl;
        end
        if (!rst_lvl || pulse) clear_all();
        for (int g = 0; g < NDUT; g++) begin
            sb_q[g].push_back({rst_lvl, ref_model(OPS[g], SATS[g], int'(a), int'(b))});
        end
    endtask

    // Monitor: one result per instance per edge, compared with the oldest queued expectation.
    initial begin
        logic [8:0] e;
        #2;
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < NDUT; g++) begin
                if (sb_q[g].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow dut%0d at %0t: got empty queue, expected an entry", g, $time);
                end else begin
                    e = sb_q[g].pop_front();
                    check("stream", g, res_w[g], e[8] ? e[7:0] : 8'h00);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_i  = 1'b0;
        a_drv    = 8'h55;
        b_drv    = 8'hAA;
        for (int g = 0; g < NDUT; g++) begin
            for (int i = 0; i < LATS[g] - 1; i++) sb_q[g].push_back(9'h000);
        end

        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) drive(8'h55, 8'hAA, 1'b0, 1'b0);
            else            drive(8'hAA, 8'h55, 1'b0, 1'b0);
        end

        for (int k = 0; k < DN; k++) begin
            for (int j = 0; j < LATS[DD[k]]; j++) drive(DA[k], DB[k], 1'b1, 1'b0);
            @(posedge clk);
            #2 check("directed", DD[k], res_w[DD[k]], DEXP[k]);
        end

        for (int i = 0; i < 100; i++) begin
            drive(8'(i), 8'(2 * i), 1'b1, (i == 50));
        end

        for (int i = 0; i < 10000; i++) begin
            drive(8'($urandom), 8'($urandom), ($urandom_range(0, 499) != 0), ($urandom_range(0, 999) == 0));
        end

        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
